// File: rtl/cr_iu_wb_arb.sv
// GPR write-port arbiter (load > MAD > EX) with a single-entry load scoreboard.
// Generates the EX interlock for RAW/WAW hazards against the outstanding load.
module cr_iu_wb_arb (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        ex_inst_vld,
  input  logic [1:0]  ex_rs_vld,
  input  logic [4:0]  ex_rs1_idx,
  input  logic [4:0]  ex_rs2_idx,
  input  logic        ex_wb_vld,
  input  logic [4:0]  ex_wb_idx,
  input  logic [31:0] ex_wb_data,
  input  logic        mad_wb_req,
  input  logic [4:0]  mad_wb_idx,
  input  logic [31:0] mad_wb_data,
  output logic        mad_wb_ack,
  input  logic        lsu_load_issue,
  input  logic [4:0]  lsu_load_idx,
  input  logic        lsu_load_done,
  input  logic        lsu_load_err,
  input  logic [31:0] lsu_load_data,
  output logic        wb_lsu_busy,
  output logic        wb_ctrl_stall,
  output logic        rf_wen,
  output logic [4:0]  rf_widx,
  output logic [31:0] rf_wdata
);

  logic       pend_vld;
  logic [4:0] pend_idx;
  logic       pend_clr;
  logic       pend_set;
  logic       ld_w;
  logic       rs1_match;
  logic       rs2_match;
  logic       waw;
  logic       haz;
  logic       mad_nz;
  logic       ex_nz;
  logic       ex_grant;

  // A done retires the old entry first, so a same-cycle issue may refill it;
  // an issue onto a live entry without a done keeps the existing entry.
  assign pend_clr = lsu_load_done & pend_vld;
  assign pend_set = lsu_load_issue & (lsu_load_idx != 5'd0) & (~pend_vld | lsu_load_done);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      pend_vld <= 1'b0;
      pend_idx <= 5'd0;
    end else begin
      if (pend_set) begin
        pend_vld <= 1'b1;
        pend_idx <= lsu_load_idx;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
    end
  end

  assign ld_w = lsu_load_done & pend_vld & ~lsu_load_err;

  // Hazard stays up through the done cycle because it looks only at pend_vld.
  assign rs1_match = ex_rs_vld[0] & (ex_rs1_idx == pend_idx) & (ex_rs1_idx != 5'd0);
  assign rs2_match = ex_rs_vld[1] & (ex_rs2_idx == pend_idx) & (ex_rs2_idx != 5'd0);
  assign waw       = ex_wb_vld & (ex_wb_idx == pend_idx);
  assign haz       = pend_vld & ex_inst_vld & (rs1_match | rs2_match | waw);

  assign mad_nz = mad_wb_req & (mad_wb_idx != 5'd0);
  assign ex_nz  = ex_wb_idx != 5'd0;

  assign mad_wb_ack = mad_wb_req & ((mad_wb_idx == 5'd0) | ~ld_w);
  assign ex_grant   = ex_wb_vld & ~haz & (~ex_nz | (~ld_w & ~mad_nz));

  assign wb_ctrl_stall = haz | (ex_wb_vld & ~ex_grant);
  assign wb_lsu_busy   = pend_vld;

  // x0 requests are acknowledged but never reach the port.
  always_comb begin
    rf_wen   = 1'b0;
    rf_widx  = 5'd0;
    rf_wdata = 32'd0;
    if (ld_w) begin
      rf_wen   = 1'b1;
      rf_widx  = pend_idx;
      rf_wdata = lsu_load_data;
    end else if (mad_nz) begin
      rf_wen   = 1'b1;
      rf_widx  = mad_wb_idx;
      rf_wdata = mad_wb_data;
    end else if (ex_grant && ex_nz) begin
      rf_wen   = 1'b1;
      rf_widx  = ex_wb_idx;
      rf_wdata = ex_wb_data;
    end
  end

endmodule

// File: tb/tb_cr_iu_wb_arb.sv
// Directed bench for cr_iu_wb_arb: stimulus pushes expectations, a negedge
// monitor pops them and compares every output of that cycle.
module tb_cr_iu_wb_arb;

  logic        forever_cpuclk;
  logic        cpurst_b;
  logic        ex_inst_vld;
  logic [1:0]  ex_rs_vld;
  logic [4:0]  ex_rs1_idx;
  logic [4:0]  ex_rs2_idx;
  logic        ex_wb_vld;
  logic [4:0]  ex_wb_idx;
  logic [31:0] ex_wb_data;
  logic        mad_wb_req;
  logic [4:0]  mad_wb_idx;
  logic [31:0] mad_wb_data;
  logic        mad_wb_ack;
  logic        lsu_load_issue;
  logic [4:0]  lsu_load_idx;
  logic        lsu_load_done;
  logic        lsu_load_err;
  logic [31:0] lsu_load_data;
  logic        wb_lsu_busy;
  logic        wb_ctrl_stall;
  logic        rf_wen;
  logic [4:0]  rf_widx;
  logic [31:0] rf_wdata;

  typedef struct packed {
    logic        wen;
    logic [4:0]  widx;
    logic [31:0] wdata;
    logic        stall;
    logic        ack;
    logic        busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  cr_iu_wb_arb dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .ex_inst_vld    (ex_inst_vld),
    .ex_rs_vld      (ex_rs_vld),
    .ex_rs1_idx     (ex_rs1_idx),
    .ex_rs2_idx     (ex_rs2_idx),
    .ex_wb_vld      (ex_wb_vld),
    .ex_wb_idx      (ex_wb_idx),
    .ex_wb_data     (ex_wb_data),
    .mad_wb_req     (mad_wb_req),
    .mad_wb_idx     (mad_wb_idx),
    .mad_wb_data    (mad_wb_data),
    .mad_wb_ack     (mad_wb_ack),
    .lsu_load_issue (lsu_load_issue),
    .lsu_load_idx   (lsu_load_idx),
    .lsu_load_done  (lsu_load_done),
    .lsu_load_err   (lsu_load_err),
    .lsu_load_data  (lsu_load_data),
    .wb_lsu_busy    (wb_lsu_busy),
    .wb_ctrl_stall  (wb_ctrl_stall),
    .rf_wen         (rf_wen),
    .rf_widx        (rf_widx),
    .rf_wdata       (rf_wdata)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, req);
    end
  endtask

  task automatic check_output(input exp_t e, input string name);
    cmp(name, "rf_wen",   {31'd0, rf_wen},        {31'd0, e.wen});
    cmp(name, "rf_widx",  {27'd0, rf_widx},       {27'd0, e.widx});
    cmp(name, "rf_wdata", rf_wdata,               e.wdata);
    cmp(name, "stall",    {31'd0, wb_ctrl_stall}, {31'd0, e.stall});
    cmp(name, "mad_ack",  {31'd0, mad_wb_ack},    {31'd0, e.ack});
    cmp(name, "busy",     {31'd0, wb_lsu_busy},   {31'd0, e.busy});
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result.
  always @(negedge forever_cpuclk) begin
    if (exp_q.size() > 0) begin
      check_output(exp_q.pop_front(), name_q.pop_front());
    end
  end

  task automatic clear_inputs();
    ex_inst_vld    = 1'b0;
    ex_rs_vld      = 2'b00;
    ex_rs1_idx     = 5'd0;
    ex_rs2_idx     = 5'd0;
    ex_wb_vld      = 1'b0;
    ex_wb_idx      = 5'd0;
    ex_wb_data     = 32'd0;
    mad_wb_req     = 1'b0;
    mad_wb_idx     = 5'd0;
    mad_wb_data    = 32'd0;
    lsu_load_issue = 1'b0;
    lsu_load_idx   = 5'd0;
    lsu_load_done  = 1'b0;
    lsu_load_err   = 1'b0;
    lsu_load_data  = 32'd0;
  endtask

  task automatic set_ex(input logic [1:0] rsv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic wbv, input logic [4:0] wbi, input logic [31:0] wbd);
    ex_inst_vld = 1'b1;
    ex_rs_vld   = rsv;
    ex_rs1_idx  = rs1;
    ex_rs2_idx  = rs2;
    ex_wb_vld   = wbv;
    ex_wb_idx   = wbi;
    ex_wb_data  = wbd;
  endtask

  // Inputs are already driven for this cycle; queue the expectation and advance.
  task automatic apply_stimulus(input string name, input logic wen, input logic [4:0] widx,
                                input logic [31:0] wdata, input logic stall, input logic ack,
                                input logic busy);
    exp_t e;
    e.wen = wen; e.widx = widx; e.wdata = wdata;
    e.stall = stall; e.ack = ack; e.busy = busy;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge forever_cpuclk);
    #1;
  endtask

  initial begin
    int guard;
    clear_inputs();
    cpurst_b = 1'b0;
    @(posedge forever_cpuclk);
    #1;
    apply_stimulus("in_reset", 0, 0, 0, 0, 0, 0);
    cpurst_b = 1'b1;
    apply_stimulus("reset_release", 0, 0, 0, 0, 0, 0);

    set_ex(2'b00, 0, 0, 1, 5'd5, 32'h1234);
    apply_stimulus("ex_only", 1, 5'd5, 32'h1234, 0, 0, 0);

    // Triple collision
    clear_inputs();
    lsu_load_issue = 1; lsu_load_idx = 5'd3;
    apply_stimulus("tri_c0", 0, 0, 0, 0, 0, 0);
    clear_inputs();
    apply_stimulus("tri_c1", 0, 0, 0, 0, 0, 1);
    lsu_load_done = 1; lsu_load_data = 32'hA;
    mad_wb_req = 1; mad_wb_idx = 5'd7; mad_wb_data = 32'h77;
    set_ex(2'b00, 0, 0, 1, 5'd9, 32'h99);
    apply_stimulus("tri_c2", 1, 5'd3, 32'hA, 1, 0, 1);
    lsu_load_done = 0; lsu_load_data = 0;
    apply_stimulus("tri_c3", 1, 5'd7, 32'h77, 1, 1, 0);
    mad_wb_req = 0; mad_wb_idx = 0; mad_wb_data = 0;
    apply_stimulus("tri_c4", 1, 5'd9, 32'h99, 0, 0, 0);

    // RAW interlock on rs2
    clear_inputs();
    lsu_load_issue = 1; lsu_load_idx = 5'd8;
    apply_stimulus("raw_issue", 0, 0, 0, 0, 0, 0);
    clear_inputs();
    set_ex(2'b10, 5'd1, 5'd8, 1, 5'd10, 32'h10);
    apply_stimulus("raw_hold0", 0, 0, 0, 1, 0, 1);
    apply_stimulus("raw_hold1", 0, 0, 0, 1, 0, 1);
    lsu_load_done = 1; lsu_load_data = 32'h88;
    apply_stimulus("raw_done", 1, 5'd8, 32'h88, 1, 0, 1);
    lsu_load_done = 0; lsu_load_data = 0;
    apply_stimulus("raw_release", 1, 5'd10, 32'h10, 0, 0, 0);

    // Load to x0 sets nothing; rs1=x0 never stalls
    clear_inputs();
    lsu_load_issue = 1; lsu_load_idx = 5'd0;
    apply_stimulus("x0_issue", 0, 0, 0, 0, 0, 0);
    clear_inputs();
    set_ex(2'b01, 5'd0, 5'd0, 1, 5'd11, 32'h11);
    apply_stimulus("x0_use", 1, 5'd11, 32'h11, 0, 0, 0);

    // Back-to-back loads
    clear_inputs();
    lsu_load_issue = 1; lsu_load_idx = 5'd4;
    apply_stimulus("b2b_issue4", 0, 0, 0, 0, 0, 0);
    lsu_load_idx = 5'd6; lsu_load_done = 1; lsu_load_data = 32'h44;
    apply_stimulus("b2b_done4_issue6", 1, 5'd4, 32'h44, 0, 0, 1);
    clear_inputs();
    set_ex(2'b01, 5'd6, 5'd0, 0, 0, 0);
    apply_stimulus("b2b_haz6", 0, 0, 0, 1, 0, 1);
    set_ex(2'b01, 5'd4, 5'd0, 0, 0, 0);
    apply_stimulus("b2b_nohaz4", 0, 0, 0, 0, 0, 1);
    clear_inputs();
    lsu_load_done = 1; lsu_load_data = 32'h66;
    apply_stimulus("b2b_done6", 1, 5'd6, 32'h66, 0, 0, 1);
    clear_inputs();
    apply_stimulus("b2b_idle", 0, 0, 0, 0, 0, 0);

    // Load error, then stray done
    lsu_load_issue = 1; lsu_load_idx = 5'd12;
    apply_stimulus("err_issue", 0, 0, 0, 0, 0, 0);
    clear_inputs();
    lsu_load_done = 1; lsu_load_err = 1; lsu_load_data = 32'hDEAD;
    set_ex(2'b00, 0, 0, 1, 5'd13, 32'h13);
    apply_stimulus("err_done_ex_wins", 1, 5'd13, 32'h13, 0, 0, 1);
    clear_inputs();
    apply_stimulus("err_busy_drop", 0, 0, 0, 0, 0, 0);
    lsu_load_done = 1; lsu_load_data = 32'hBEEF;
    apply_stimulus("stray_done", 0, 0, 0, 0, 0, 0);

    // x0 MAD/EX requests pass alongside a load write
    clear_inputs();
    lsu_load_issue = 1; lsu_load_idx = 5'd15;
    apply_stimulus("x0req_issue", 0, 0, 0, 0, 0, 0);
    clear_inputs();
    lsu_load_done = 1; lsu_load_data = 32'h55;
    mad_wb_req = 1; mad_wb_idx = 5'd0; mad_wb_data = 32'hFF;
    set_ex(2'b00, 0, 0, 1, 5'd0, 32'hEE);
    apply_stimulus("x0req_load", 1, 5'd15, 32'h55, 0, 1, 1);

    // Asynchronous reset mid-load drops the entry
    clear_inputs();
    lsu_load_issue = 1; lsu_load_idx = 5'd14;
    apply_stimulus("rst_issue", 0, 0, 0, 0, 0, 0);
    clear_inputs();
    apply_stimulus("rst_busy", 0, 0, 0, 0, 0, 1);
    cpurst_b = 1'b0;
    #2;
    cpurst_b = 1'b1;
    lsu_load_done = 1; lsu_load_data = 32'h1414;
    set_ex(2'b01, 5'd14, 5'd0, 1, 5'd16, 32'h16);
    apply_stimulus("rst_dropped", 1, 5'd16, 32'h16, 0, 0, 0);
    clear_inputs();

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge forever_cpuclk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_iu_wb_arb.md
# cr_iu_wb_arb

Register-file write-port arbiter and load scoreboard for the IU. It shares the single GPR write port between three sources: the LSU load return, the multi-cycle MAD unit, and the single-cycle EX result (ALU/CP0/special). It tracks the one outstanding load destination and generates the EX interlock `wb_ctrl_stall` consumed by the IU control stall logic.

## Interface
Parameters: none.

Ports:
- forever_cpuclk  in  1  core clock.
- cpurst_b  in  1  asynchronous reset, active low.
- ex_inst_vld  in  1  valid instruction in EX, whether or not it writes back.
- ex_rs_vld  in  2  [0]=rs1 used, [1]=rs2 used.
- ex_rs1_idx, ex_rs2_idx  in  5  source register indices.
- ex_wb_vld  in  1  EX result write request; only asserted with ex_inst_vld.
- ex_wb_idx  in  5  EX destination register.
- ex_wb_data  in  32  EX result.
- mad_wb_req  in  1  MAD result request; held until acknowledged.
- mad_wb_idx  in  5  MAD destination register.
- mad_wb_data  in  32  MAD result.
- mad_wb_ack  out  1  MAD result accepted this cycle.
- lsu_load_issue  in  1  load accepted by bus this cycle.
- lsu_load_idx  in  5  destination of the issued load.
- lsu_load_done  in  1  load data returns this cycle; cannot be stalled.
- lsu_load_err  in  1  qualifies done with a bus error: no write.
- lsu_load_data  in  32  load data.
- wb_lsu_busy  out  1  a load is outstanding; LSU must not issue another.
- wb_ctrl_stall  out  1  EX must hold this cycle.
- rf_wen  out  1  GPR write enable.
- rf_widx  out  5  GPR write index.
- rf_wdata  out  32  GPR write data.

## Operation
- State:
  - pend_vld: 1 bit.
  - pend_idx: 5 bits.
  - No other storage.
- Set: lsu_load_issue with lsu_load_idx!=0 sets pend_vld=1 and pend_idx=lsu_load_idx. A load to x0 sets nothing.
- Clear: lsu_load_done (error or not) with pend_vld=1 clears pend_vld.
  - Done and issue in the same cycle: the done applies to the old entry; the new entry is loaded (back-to-back loads).
- A done with pend_vld=0 is ignored: no write, no state change.
- An issue while pend_vld=1 with no same-cycle done is a protocol violation. The existing entry is kept.
- Load write: `ld_w = lsu_load_done & pend_vld & !lsu_load_err`.
- Hazard `haz = pend_vld & ex_inst_vld & (rs1_match | rs2_match | waw)`.
  - rs1_match: ex_rs_vld[0] & ex_rs1_idx==pend_idx & ex_rs1_idx!=0. rs2_match is the same on rs2.
  - waw: ex_wb_vld & ex_wb_idx==pend_idx.
  - The hazard holds through the done cycle and releases the following cycle.
- Fixed priority for the port: load > MAD > EX.
  - A request with index 0 never occupies the port and is acknowledged immediately without writing.
  - mad_wb_ack = mad_wb_req & (mad_wb_idx==0 | !ld_w).
  - EX granted = ex_wb_vld & !haz & (ex_wb_idx==0 | (!ld_w & !(mad_wb_req & mad_wb_idx!=0))).
- wb_ctrl_stall = haz | (ex_wb_vld & !EX granted).
- rf_wen/rf_widx/rf_wdata are combinational from the winning non-x0 source. With no winner: rf_wen=0, idx=0, data=0.
- wb_lsu_busy = pend_vld.
- No combinational loop: ex_wb_vld and mad_wb_req must not depend on wb_ctrl_stall or mad_wb_ack.

## Timing
- Reset (async, cpurst_b low): pend_vld=0, pend_idx=0. Hence wb_lsu_busy=0 and the hazard is inactive.
  - The other outputs follow the inputs combinationally: rf_wen=0, wb_ctrl_stall=0 and mad_wb_ack=0 when all requests are low.
- Reset mid-load drops the scoreboard entry. A later done is then ignored.
- Zero-latency grant: the write happens in the request cycle. A losing EX or MAD request is re-presented the next cycle.
- The earliest EX consumer of a load reg is released the cycle after lsu_load_done.
- MAD starvation is bounded: at most one load write per outstanding load.

## Test plan
- Reset release, all inputs 0 -> rf_wen=0, wb_lsu_busy=0, wb_ctrl_stall=0.
- EX-only write: ex_wb_vld, idx=5, data=0x1234 -> rf_wen=1, rf_widx=5, rf_wdata=0x1234 the same cycle, no stall.
- Triple collision, 4 cycles:
  - Cycle 0: load issue idx 3.
  - Cycle 2: done data 0xA, MAD idx 7, EX idx 9 all request. Expect write x3=0xA, mad_wb_ack=0, stall=1.
  - Cycle 3: expect write x7, ack=1, stall=1.
  - Cycle 4: expect write x9, stall=0.
- RAW interlock: load to x8 pending, EX uses rs2=x8 -> stall every cycle through the done cycle, released the next cycle. rs1=x0 with a load to x0 -> no stall.
- Back-to-back loads: done(idx 4) with issue(idx 6) in the same cycle -> x4 written, pend_idx=6, busy stays 1.
- Load error: done with lsu_load_err=1 -> rf_wen=0, busy drops, a same-cycle EX write wins. Then a stray done with no pending load -> no write.
